// File: rtl/fetch_stage.sv
// Instruction-fetch stage: sequential PC, one outstanding memory request at a time,
// fetched word delivered to decode as a one-cycle pulse with NOP bubbles otherwise.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] reg_pc,
    output logic [31:0] inst,
    output logic        mem_start,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_data_valid,
    output logic        dbg_state
);

    // Memory handshake: a request is issued by a one-cycle mem_start pulse while
    // mem_ready is high; the answer is the first mem_data_valid cycle after it,
    // and mem_addr stays stable for the whole time the request is outstanding.
    typedef enum logic {
        S_ISSUE = 1'b0,
        S_WAIT  = 1'b1
    } state_t;

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_reg_pc;
    logic [31:0] r_inst;
    logic        r_mem_start;
    logic [31:0] r_mem_addr;

    logic        w_issue;
    logic        w_deliver;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_reg_pc_nxt;
    logic [31:0] w_inst_nxt;
    logic        w_mem_start_nxt;
    logic [31:0] w_mem_addr_nxt;

    assign w_issue   = (r_state == S_ISSUE) && mem_ready;
    assign w_deliver = (r_state == S_WAIT) && mem_data_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_ISSUE;
            r_pc        <= PC_INIT;
            r_reg_pc    <= PC_INIT;
            r_inst      <= NOP_INST;
            r_mem_start <= 1'b0;
            r_mem_addr  <= PC_INIT;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_reg_pc    <= w_reg_pc_nxt;
            r_inst      <= w_inst_nxt;
            r_mem_start <= w_mem_start_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ISSUE: if (mem_ready)      w_state_nxt = S_WAIT;
            S_WAIT:  if (mem_data_valid) w_state_nxt = S_ISSUE;
            default:                     w_state_nxt = S_ISSUE;
        endcase
    end

    // Valid arriving in ISSUE (stale or premature) never reaches decode.
    always_comb begin
        w_mem_start_nxt = w_issue;
        w_mem_addr_nxt  = w_issue ? r_pc : r_mem_addr;
        w_inst_nxt      = w_deliver ? mem_data : NOP_INST;
        w_reg_pc_nxt    = w_deliver ? r_pc : r_reg_pc;
        w_pc_nxt        = w_deliver ? r_pc + 32'd4 : r_pc;
    end

    assign reg_pc    = r_reg_pc;
    assign inst      = r_inst;
    assign mem_start = r_mem_start;
    assign mem_addr  = r_mem_addr;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed steps plus randomized memory timing,
// checked against a transaction-count model of the fetch sequence.
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] BASE_B = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mem_ready;
    logic        mem_data_valid;
    logic [31:0] mem_data;

    logic [31:0] a_reg_pc, a_inst, a_mem_addr;
    logic        a_mem_start, a_state;
    logic [31:0] b_reg_pc, b_inst, b_mem_addr;
    logic        b_mem_start, b_state;

    fetch_stage #(.RESET_PC(BASE_A), .NOP_INST(NOP)) dut_a (
        .clk(clk), .rst_n(rst_n), .reg_pc(a_reg_pc), .inst(a_inst),
        .mem_start(a_mem_start), .mem_ready(mem_ready), .mem_addr(a_mem_addr),
        .mem_data(mem_data), .mem_data_valid(mem_data_valid), .dbg_state(a_state)
    );

    fetch_stage #(.RESET_PC(BASE_B), .NOP_INST(NOP)) dut_b (
        .clk(clk), .rst_n(rst_n), .reg_pc(b_reg_pc), .inst(b_inst),
        .mem_start(b_mem_start), .mem_ready(mem_ready), .mem_addr(b_mem_addr),
        .mem_data(mem_data), .mem_data_valid(mem_data_valid), .dbg_state(b_state)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: fetch k (counted from reset) targets base + 4*k.
    int issued;
    int delivered;
    bit outstanding;

    function automatic logic [31:0] addr_of(input logic [31:0] base, input int k);
        return base + 32'(4 * k);
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] base);
        return (issued == 0) ? base : addr_of(base, issued - 1);
    endfunction

    function automatic logic [31:0] exp_pc(input logic [31:0] base);
        return (delivered == 0) ? base : addr_of(base, delivered - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance, update model, compare every output.
    task automatic cycle(input logic rst, input logic ready, input logic valid,
                         input logic [31:0] data);
        logic issue, deliver;
        logic [31:0] exp_inst;
        rst_n          = rst;
        mem_ready      = ready;
        mem_data_valid = valid;
        mem_data       = data;
        issue   = rst && !outstanding && ready;
        deliver = rst && outstanding && valid;
        @(posedge clk);
        #1;
        if (!rst) begin
            issued = 0; delivered = 0; outstanding = 1'b0;
        end else if (issue) begin
            issued++; outstanding = 1'b1;
        end else if (deliver) begin
            delivered++; outstanding = 1'b0;
        end
        exp_inst = deliver ? data : NOP;
        chk("a_mem_start", {31'b0, a_mem_start}, {31'b0, issue});
        chk("a_mem_addr",  a_mem_addr, exp_addr(BASE_A));
        chk("a_inst",      a_inst, exp_inst);
        chk("a_reg_pc",    a_reg_pc, exp_pc(BASE_A));
        chk("a_state",     {31'b0, a_state}, {31'b0, outstanding});
        chk("b_mem_start", {31'b0, b_mem_start}, {31'b0, issue});
        chk("b_mem_addr",  b_mem_addr, exp_addr(BASE_B));
        chk("b_inst",      b_inst, exp_inst);
        chk("b_reg_pc",    b_reg_pc, exp_pc(BASE_B));
    endtask

    // Issue one request, keep ready high while waiting, answer after 'delay' cycles.
    task automatic fetch_once(input int delay);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (delay - 1) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, addr_of(BASE_A, issued - 1) + 32'h100);
    endtask

    initial begin
        logic r, rdy, vld;
        issued = 0; delivered = 0; outstanding = 1'b0;
        rst_n = 1'b0; mem_ready = 1'b0; mem_data_valid = 1'b0; mem_data = 32'h0;

        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'h1234_5678);

        repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (6) fetch_once(1);
        repeat (3) fetch_once(4);

        repeat (2) cycle(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        cycle(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        cycle(1'b1, 1'b0, 1'b1, 32'hCAFE_0001);

        // Valid response while ready is low is still captured.
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h5555_AAAA);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (8) fetch_once(1);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        chk("a_addr_before_abort", a_mem_addr, 32'h0000_0020);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'hBAD0_BAD0);
        fetch_once(2);

        repeat (400) begin
            r   = ($urandom_range(0, 99) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            vld = outstanding ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
            cycle(r, rdy, vld, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
